// File: rtl/arb_resp_router.sv
// arb_resp_router: in-order grant tag FIFO steering shared responses back to requesters; ARB_RESP_ROUTER_BYPASS_EN enables empty-FIFO bypass
module arb_resp_router #(
  parameter int N     = 2,
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [N-1:0]               gnt,
  input  logic                       issue_fire,
  input  logic                       issue_last,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  input  logic                       rsp_valid,
  output logic                       rsp_ready,
  input  logic [W-1:0]               rsp_data,
  input  logic                       rsp_last,
  output logic [N-1:0]               out_valid,
  input  logic [N-1:0]               out_ready,
  output logic [W-1:0]               out_data,
  output logic                       out_last,
  output logic                       err
);
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic [CW-1:0] count, count_nxt;
  logic [IW-1:0] gidx, head;
  logic          push_req, push_ok, byp, hv, pop, err_set, nonempty;
  always_comb begin
    gidx = '0;
    for (int i = N-1; i >= 0; i--) gidx = gnt[i] ? IW'(i) : gidx;
  end
  assign push_req = issue_fire & issue_last;
  assign push_ok  = push_req & (|gnt) & ~full;
  assign nonempty = count != '0;
`ifdef ARB_RESP_ROUTER_BYPASS_EN
  assign byp = push_ok & ~nonempty;
`else
  assign byp = 1'b0;
`endif
  assign hv        = nonempty | byp;
  assign head      = nonempty ? mem[rd] : gidx;
  assign out_valid = (rsp_valid & hv) ? ({{(N-1){1'b0}}, 1'b1} << head) : '0;
  assign rsp_ready = hv & out_ready[head];
  assign out_data  = rsp_data;
  assign out_last  = rsp_last;
  assign pending   = count;
  assign pop       = rsp_valid & rsp_ready & rsp_last;
  assign err_set   = (push_req & (full | ~(|gnt))) | (rsp_valid & ~hv);
  assign count_nxt = count + CW'(push_ok) - CW'(pop);
  // a bypassed entry is still written so both pointers advance together
  always_ff @(posedge clk) if (push_ok) mem[wr] <= gidx;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
      full  <= 1'b0;
      err   <= 1'b0;
    end else begin
      wr    <= wr + PW'(push_ok);
      rd    <= rd + PW'(pop);
      count <= count_nxt;
      full  <= count_nxt == CW'(DEPTH);
      err   <= err | err_set;
    end
  end
endmodule

// File: tb/tb_arb_resp_router.sv
// tb_arb_resp_router: randomized scoreboard bench for arb_resp_router against a queue-based reference model
module tb_arb_resp_router;
  localparam int N = 2, W = 64, DEPTH = 4, CW = $clog2(DEPTH+1);
  logic clk = 0, rstn = 0;
  logic [N-1:0] gnt = '0, out_ready = '0, out_valid;
  logic issue_fire = 0, issue_last = 0, rsp_valid = 0, rsp_last = 0;
  logic full, rsp_ready, out_last, err;
  logic [CW-1:0] pending;
  logic [W-1:0] rsp_data = '0, out_data;
  typedef struct {int port; logic [W-1:0] d; logic l;} beat_t;
  beat_t sb[$];
  int mq[$];
  bit merr;
  logic [N-1:0] exp_ov = '0;
  logic exp_rdy = 0;
  int checks = 0, failures = 0;

  arb_resp_router #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .gnt(gnt), .issue_fire(issue_fire), .issue_last(issue_last),
    .full(full), .pending(pending), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .err(err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // drive one cycle of stimulus at posedge+1, predict it, then advance past the next edge
  task automatic step(input logic [N-1:0] g, input logic f, input logic l, input logic v,
                      input logic [W-1:0] d, input logic rl, input logic [N-1:0] r);
    int sz, gi, hd;
    bit pr, pok, byp, hv;
    logic [N-1:0] one;
    gnt = g; issue_fire = f; issue_last = l; rsp_valid = v; rsp_data = d; rsp_last = rl; out_ready = r;
    sz = mq.size(); pr = f & l; gi = 0; one = 1;
    for (int i = N-1; i >= 0; i--) if (g[i]) gi = i;
    pok = pr && g != 0 && sz != DEPTH;
    byp = 0;
`ifdef ARB_RESP_ROUTER_BYPASS_EN
    byp = pok && sz == 0;
`endif
    hv = sz != 0 || byp;
    hd = sz != 0 ? mq[0] : gi;
    exp_ov = (v && hv) ? one << hd : '0;
    exp_rdy = hv && r[hd];
    if (v && exp_rdy) sb.push_back('{hd, d, rl});
    if ((pr && (sz == DEPTH || g == 0)) || (v && !hv)) merr = 1;
    if (pok) mq.push_back(gi);
    if (v && exp_rdy && rl) void'(mq.pop_front());
    @(posedge clk); #1;
    chk("pending", 64'(pending), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("err", 64'(err), 64'(merr));
  endtask

  task automatic do_reset();
    issue_fire = 0;
    rstn = 0;
    #1;
    chk("rst_pending", 64'(pending), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_rsp_ready", 64'(rsp_ready), 64'(0));
    chk("sb_drained", 64'(sb.size()), 64'(0));
    gnt = '0; issue_last = 0; rsp_valid = 0; rsp_last = 0; out_ready = '0;
    exp_ov = '0; exp_rdy = 0; merr = 0;
    mq.delete(); sb.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  always @(negedge clk) begin
    beat_t b;
    logic [N-1:0] one;
    one = 1;
    chk("out_valid", 64'(out_valid), 64'(exp_ov));
    chk("rsp_ready", 64'(rsp_ready), 64'(exp_rdy));
    if (|(out_valid & out_ready)) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat actual=%0h required=none", out_valid);
      end else begin
        b = sb.pop_front();
        chk("beat_port", 64'(out_valid), 64'(one << b.port));
        chk("beat_data", out_data, b.d);
        chk("beat_last", 64'(out_last), 64'(b.l));
      end
    end
  end

  initial begin
    int ph, pp, pv;
    logic [N-1:0] g;
    do_reset();
    step(2'b01, 1, 1, 0, 0, 0, 0);
    chk("t1_pending1", 64'(pending), 64'(1));
    step(2'b10, 1, 1, 0, 0, 0, 0);
    chk("t1_pending2", 64'(pending), 64'(2));
    step(0, 0, 0, 1, 64'hA, 1, 2'b11);
    chk("t1_pending_a", 64'(pending), 64'(1));
    step(0, 0, 0, 1, 64'hB, 1, 2'b11);
    chk("t1_pending_b", 64'(pending), 64'(0));
    step(2'b10, 1, 1, 0, 0, 0, 0);
    repeat (2) begin
      step(0, 0, 0, 1, 64'h1, 0, 2'b01);
      chk("t2_stall_rdy", 64'(rsp_ready), 64'(0));
      chk("t2_stall_ov", 64'(out_valid), 64'(2));
    end
    step(0, 0, 0, 1, 64'h1, 0, 2'b10);
    step(0, 0, 0, 1, 64'h2, 0, 2'b11);
    chk("t2_no_pop", 64'(pending), 64'(1));
    step(0, 0, 0, 1, 64'h3, 1, 2'b11);
    chk("t2_pop", 64'(pending), 64'(0));
    for (int i = 0; i < 4; i++) step(i[0] ? 2'b10 : 2'b01, 1, 1, 0, 0, 0, 0);
    chk("t3_full", 64'(full), 64'(1));
    chk("t3_pending4", 64'(pending), 64'(4));
    chk("t3_err0", 64'(err), 64'(0));
    step(2'b01, 1, 1, 0, 0, 0, 0);
    chk("t3_overflow_err", 64'(err), 64'(1));
    chk("t3_overflow_pending", 64'(pending), 64'(4));
    step(0, 0, 0, 1, 64'h44, 1, 2'b11);
    chk("t3_pop_pending", 64'(pending), 64'(3));
    step(2'b10, 1, 1, 1, 64'h55, 1, 2'b11);
    chk("t3_pushpop_pending", 64'(pending), 64'(3));
    step(0, 0, 0, 1, 64'h66, 0, 2'b11);
    do_reset();
    step(0, 0, 0, 1, 64'h77, 1, 2'b11);
    chk("t6_stale_rsp_err", 64'(err), 64'(1));
    do_reset();
    step(2'b00, 1, 1, 0, 0, 0, 0);
    chk("t4_gnt0_err", 64'(err), 64'(1));
    chk("t4_gnt0_pending", 64'(pending), 64'(0));
    do_reset();
    step(0, 0, 0, 1, 64'h9, 1, 2'b11);
    chk("t4_empty_err", 64'(err), 64'(1));
    do_reset();
    step(2'b10, 1, 1, 1, 64'hBEEF, 1, 2'b11);
`ifdef ARB_RESP_ROUTER_BYPASS_EN
    chk("t5_byp_pending", 64'(pending), 64'(0));
    chk("t5_byp_err", 64'(err), 64'(0));
`else
    chk("t5_nobyp_pending", 64'(pending), 64'(1));
    chk("t5_nobyp_err", 64'(err), 64'(1));
`endif
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 250 == 249) do_reset();
      ph = (k / 40) % 2;
      pp = ph ? 70 : 25;
      pv = ph ? 45 : 85;
      g = $urandom_range(0, 39) == 0 ? 2'b00 : $urandom_range(0, 9) == 0 ? 2'b11 : $urandom_range(0, 1) ? 2'b10 : 2'b01;
      step(g, 1'($urandom_range(0, 99) < pp), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 99) < pv), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           N'($urandom));
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("sb_empty_end", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
